// File: rtl/sr_fifo_pkg.sv
// Shared constants and helpers for the sr_fifo family.
// Default geometry used by the UART/trace peripherals, plus explicit pointer wrap for any DEPTH.
// No logic, no latency, no backpressure.
package sr_fifo_pkg;

    localparam int SR_FIFO_WIDTH = 8;
    localparam int SR_FIFO_DEPTH = 8;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic int next_ptr(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sr_fifo_sync_if.sv
// Push/pop/status bundle between an sr_fifo_sync instance and its user.
// Pure wiring: no latency, no backpressure of its own.
// master = producer/consumer side, slave = FIFO side.
interface sr_fifo_sync_if #(
    parameter int WIDTH = sr_fifo_pkg::SR_FIFO_WIDTH,
    parameter int DEPTH = sr_fifo_pkg::SR_FIFO_DEPTH
);
    localparam int AW = $clog2(DEPTH);

    logic             flush;
    logic             write_enable;
    logic [WIDTH-1:0] write_data;
    logic             read_enable;
    logic [WIDTH-1:0] read_data;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, write_enable, write_data, read_enable,
        input  read_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, write_enable, write_data, read_enable,
        output read_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/sr_fifo_mem.sv
// DEPTH x WIDTH storage, one write port, one read port; contents are never reset.
// Read: combinational under SR_FIFO_FWFT_EN, otherwise registered (1 cycle, held when rd_en_i low).
// No backpressure: the caller only enables ports for accepted transfers.
module sr_fifo_mem
    import sr_fifo_pkg::*;
#(
    parameter int WIDTH = SR_FIFO_WIDTH,
    parameter int DEPTH = SR_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

`ifdef SR_FIFO_FWFT_EN
    assign rd_data_o = mem_q[rd_addr_i];

    logic unused_rd_ctrl;
    assign unused_rd_ctrl = ^{rst, rd_en_i};
`else
    logic [WIDTH-1:0] rd_data_q;

    // A same-address write in this edge is not visible yet, so a pass-through pop gets the old head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;
`endif

endmodule

// File: rtl/sr_fifo_sync.sv
// Parametrised single-clock FIFO with count, almost thresholds, sticky over/underflow and flush.
// Read latency 1 cycle (registered); 0 cycles with SR_FIFO_FWFT_EN defined (first-word-fall-through).
// Writes rejected when full unless a pop happens in the same cycle; rejected requests set sticky flags.
module sr_fifo_sync
    import sr_fifo_pkg::*;
#(
    parameter int WIDTH     = SR_FIFO_WIDTH,
    parameter int DEPTH     = SR_FIFO_DEPTH,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic          clk,
    input  logic          reset,
    sr_fifo_sync_if.slave bus
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             full_w, empty_w;
    logic             rd_acc, wr_acc;
    logic             mem_we, mem_re;
    logic [WIDTH-1:0] rd_data_w;

    assign full_w  = (count_q == FULL_CNT);
    assign empty_w = (count_q == '0);

    assign rd_acc = bus.read_enable & ~empty_w;
    assign wr_acc = bus.write_enable & (~full_w | rd_acc);

    // Flush wins over any same-cycle transfer, so storage and read register stay untouched.
    assign mem_we = wr_acc & ~bus.flush;
    assign mem_re = rd_acc & ~bus.flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = AW'(next_ptr(int'(wr_ptr_q), DEPTH));
            end
            if (rd_acc) begin
                rd_ptr_d = AW'(next_ptr(int'(rd_ptr_q), DEPTH));
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            ovf_d = ovf_q | (bus.write_enable & ~wr_acc);
            udf_d = udf_q | (bus.read_enable & ~rd_acc);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    sr_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .rst       (reset),
        .wr_en_i   (mem_we),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (bus.write_data),
        .rd_en_i   (mem_re),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data_w)
    );

    assign bus.read_data    = rd_data_w;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (int'(count_q) >= AFULL_TH);
    assign bus.almost_empty = (int'(count_q) <= AEMPTY_TH);
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sr_fifo_sync.sv
// Directed bench for sr_fifo_sync at DEPTH=8 and DEPTH=5, scoreboard queues per instance.
// Works in both the registered-read and the SR_FIFO_FWFT_EN builds.
module tb_sr_fifo_sync;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sr_fifo_sync_if #(.WIDTH(8), .DEPTH(8)) b8 ();
    sr_fifo_sync_if #(.WIDTH(8), .DEPTH(5)) b5 ();

    sr_fifo_sync #(.WIDTH(8), .DEPTH(8)) dut8 (.clk(clk), .reset(reset), .bus(b8));
    sr_fifo_sync #(.WIDTH(8), .DEPTH(5)) dut5 (.clk(clk), .reset(reset), .bus(b5));

    logic [7:0] q8[$];
    logic [7:0] q5[$];
    bit         ovf8, udf8, ovf5, udf5;
    logic [7:0] last8, last5;
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_state(input bit s5);
        if (s5) begin
            chk("d5_count",  32'(b5.count),        32'(q5.size()));
            chk("d5_full",   32'(b5.full),         32'(q5.size() == 5));
            chk("d5_empty",  32'(b5.empty),        32'(q5.size() == 0));
            chk("d5_afull",  32'(b5.almost_full),  32'(q5.size() >= 4));
            chk("d5_aempty", 32'(b5.almost_empty), 32'(q5.size() <= 1));
            chk("d5_ovf",    32'(b5.overflow),     32'(ovf5));
            chk("d5_udf",    32'(b5.underflow),    32'(udf5));
        end else begin
            chk("d8_count",  32'(b8.count),        32'(q8.size()));
            chk("d8_full",   32'(b8.full),         32'(q8.size() == 8));
            chk("d8_empty",  32'(b8.empty),        32'(q8.size() == 0));
            chk("d8_afull",  32'(b8.almost_full),  32'(q8.size() >= 7));
            chk("d8_aempty", 32'(b8.almost_empty), 32'(q8.size() <= 1));
            chk("d8_ovf",    32'(b8.overflow),     32'(ovf8));
            chk("d8_udf",    32'(b8.underflow),    32'(udf8));
        end
    endtask

    task automatic check_rd(input bit s5);
`ifdef SR_FIFO_FWFT_EN
        if (s5 && q5.size() > 0) chk("d5_head", 32'(b5.read_data), 32'(q5[0]));
        if (!s5 && q8.size() > 0) chk("d8_head", 32'(b8.read_data), 32'(q8[0]));
`else
        if (s5) chk("d5_rdata", 32'(b5.read_data), 32'(last5));
        else    chk("d8_rdata", 32'(b8.read_data), 32'(last8));
`endif
    endtask

    // One clock of stimulus on the selected FIFO; the model applies the acceptance rules.
    task automatic cyc(input bit s5, input bit w, input bit r, input logic [7:0] d);
        int         n;
        int         dep;
        bit         racc, wacc;
        logic [7:0] expv;
        dep  = s5 ? 5 : 8;
        n    = s5 ? q5.size() : q8.size();
        racc = r && (n > 0);
        wacc = w && ((n < dep) || racc);
        expv = 8'h00;
        if (racc) begin
            if (s5) expv = q5.pop_front();
            else    expv = q8.pop_front();
        end
        if (wacc) begin
            if (s5) q5.push_back(d);
            else    q8.push_back(d);
        end
        if (s5) begin
            ovf5 = ovf5 | (w && !wacc);
            udf5 = udf5 | (r && !racc);
        end else begin
            ovf8 = ovf8 | (w && !wacc);
            udf8 = udf8 | (r && !racc);
        end
`ifdef SR_FIFO_FWFT_EN
        if (racc) chk(s5 ? "d5_pop" : "d8_pop", 32'(s5 ? b5.read_data : b8.read_data), 32'(expv));
`else
        if (racc) begin
            if (s5) last5 = expv;
            else    last8 = expv;
        end
`endif
        if (s5) begin
            b5.write_enable = w; b5.read_enable = r; b5.write_data = d;
        end else begin
            b8.write_enable = w; b8.read_enable = r; b8.write_data = d;
        end
        @(negedge clk);
        b5.write_enable = 1'b0; b5.read_enable = 1'b0;
        b8.write_enable = 1'b0; b8.read_enable = 1'b0;
        check_rd(s5);
        check_state(s5);
    endtask

    task automatic do_flush(input bit s5, input bit w, input bit r, input logic [7:0] d);
        if (s5) begin
            b5.flush = 1'b1; b5.write_enable = w; b5.read_enable = r; b5.write_data = d;
        end else begin
            b8.flush = 1'b1; b8.write_enable = w; b8.read_enable = r; b8.write_data = d;
        end
        @(negedge clk);
        b5.flush = 1'b0; b5.write_enable = 1'b0; b5.read_enable = 1'b0;
        b8.flush = 1'b0; b8.write_enable = 1'b0; b8.read_enable = 1'b0;
        if (s5) begin
            q5.delete(); ovf5 = 1'b0; udf5 = 1'b0;
        end else begin
            q8.delete(); ovf8 = 1'b0; udf8 = 1'b0;
        end
        check_rd(s5);
        check_state(s5);
    endtask

    task automatic clear_model();
        q8.delete(); q5.delete();
        ovf8 = 1'b0; udf8 = 1'b0; ovf5 = 1'b0; udf5 = 1'b0;
        last8 = 8'h00; last5 = 8'h00;
    endtask

    initial begin
        reset = 1'b1;
        b8.flush = 1'b0; b8.write_enable = 1'b0; b8.read_enable = 1'b0; b8.write_data = 8'h00;
        b5.flush = 1'b0; b5.write_enable = 1'b0; b5.read_enable = 1'b0; b5.write_data = 8'h00;
        clear_model();
        @(negedge clk);
        @(negedge clk);
        check_state(0); check_state(1);
        check_rd(0);    check_rd(1);
        reset = 1'b0;
        @(negedge clk);

        // Fill DEPTH=8, then one rejected write.
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 8'(8'h11 + i));
        cyc(0, 1, 0, 8'h99);
        // Drain in order, then one rejected read.
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 8'h00);
        cyc(0, 0, 1, 8'h00);
        do_flush(0, 0, 0, 8'h00);

        // Read+write on empty: write only, underflow set.
        cyc(0, 1, 1, 8'h42);
        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 8'(8'h50 + i));
        // Read+write on full: pass-through, no overflow.
        cyc(0, 1, 1, 8'h60);
        do_flush(0, 0, 0, 8'h00);

        // Flush with count=3, flags set and a concurrent write.
        cyc(0, 0, 1, 8'h00);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 8'(8'h70 + i));
        do_flush(0, 1, 0, 8'hEE);
        cyc(0, 0, 0, 8'h00);

        // Head exposure and pop-advance behaviour.
        cyc(0, 1, 0, 8'hA5);
        cyc(0, 0, 0, 8'h00);
        cyc(0, 1, 0, 8'hB6);
        cyc(0, 0, 1, 8'h00);
        cyc(0, 0, 1, 8'h00);

        // DEPTH=5: pointers wrap several times with concurrent traffic.
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 8'(8'h20 + i));
        for (int i = 0; i < 12; i++) cyc(1, 1, 1, 8'(8'h30 + i));
        cyc(1, 1, 0, 8'h3C);
        cyc(1, 1, 0, 8'h3D);
        for (int i = 0; i < 6; i++) cyc(1, 0, 1, 8'h00);

        // Reset mid-burst: outputs must clear before the next clock edge.
        cyc(0, 1, 0, 8'hC1);
        cyc(0, 1, 0, 8'hC2);
        b8.write_enable = 1'b1;
        b8.write_data   = 8'hC3;
        #2;
        reset = 1'b1;
        #1;
        clear_model();
        check_state(0); check_state(1);
        check_rd(0);    check_rd(1);
        @(negedge clk);
        check_state(0);
        reset = 1'b0;
        b8.write_enable = 1'b0;
        cyc(0, 0, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
